// File: rtl/pc_sequencer.sv
// Program-counter sequencer: holds the PC, selects the next fetch address
// for sequential, PC-relative, register and return flows, and predicts RET
// targets with a small circular return-address stack.
//
// Ports:
//   CLK, Reset (async, active-high), Stall (hold all state)
//   Branch/ALUZero    CBZ-style branch, taken when ALUZero
//   Uncondbranch      B/BL, always taken
//   CondBranch        B.cond, CondCode evaluated on Flags {N,Z,C,V}
//   BranchReg, Ret    register branch / return (RAS top or RegTarget)
//   Link              push PC+4 onto the RAS
//   RegTarget         register operand for BR/RET
//   SignExtImm        signed word offset
//   PC                registered current PC
//   NextPC, Taken     combinational next PC and redirect flag
//   RasCount/RasEmpty RAS occupancy
module pc_sequencer #(
    parameter int               WIDTH     = 64,
    parameter int               RAS_DEPTH = 4,
    parameter logic [WIDTH-1:0] RESET_PC  = '0
) (
    input  logic                         CLK,
    input  logic                         Reset,
    input  logic                         Stall,
    input  logic                         Branch,
    input  logic                         ALUZero,
    input  logic                         Uncondbranch,
    input  logic                         CondBranch,
    input  logic [3:0]                   CondCode,
    input  logic [3:0]                   Flags,
    input  logic                         BranchReg,
    input  logic                         Ret,
    input  logic                         Link,
    input  logic [WIDTH-1:0]             RegTarget,
    input  logic [WIDTH-1:0]             SignExtImm,
    output logic [WIDTH-1:0]             PC,
    output logic [WIDTH-1:0]             NextPC,
    output logic                         Taken,
    output logic [$clog2(RAS_DEPTH):0]   RasCount,
    output logic                         RasEmpty
);

    localparam int PW = $clog2(RAS_DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] FULL = CW'(RAS_DEPTH);

    logic [WIDTH-1:0] ras [RAS_DEPTH];
    logic [PW-1:0]    top;
    logic [CW-1:0]    cnt;

    logic [WIDTH-1:0] seq;
    logic [WIDTH-1:0] brt;
    logic [WIDTH-1:0] regtgt;
    logic             n, z, c, v;
    logic             base;
    logic             cond_ok;
    logic             empty;
    logic             push;
    logic             pop;
    logic             ovw;
    logic [PW-1:0]    wr_idx;

    assign {n, z, c, v} = Flags;

    assign seq    = PC + WIDTH'(4);
    assign brt    = PC + (SignExtImm << 2);
    assign regtgt = RegTarget & ~WIDTH'(3);

    assign empty    = (cnt == '0);
    assign RasCount = cnt;
    assign RasEmpty = empty;

    // Even codes test the base condition, odd codes its inverse;
    // the 111x pair (AL/NV) is always true.
    always_comb begin
        base = 1'b0;
        unique case (CondCode[3:1])
            3'b000: base = z;
            3'b001: base = c;
            3'b010: base = n;
            3'b011: base = v;
            3'b100: base = c & ~z;
            3'b101: base = (n == v);
            3'b110: base = ~z & (n == v);
            3'b111: base = 1'b1;
        endcase
        cond_ok = (CondCode[3:1] == 3'b111) ? 1'b1 : (base ^ CondCode[0]);
    end

    always_comb begin
        NextPC = seq;
        Taken  = 1'b1;
        if (Ret)
            NextPC = empty ? regtgt : ras[top];
        else if (BranchReg)
            NextPC = regtgt;
        else if (Uncondbranch || (Branch && ALUZero) || (CondBranch && cond_ok))
            NextPC = brt;
        else
            Taken = 1'b0;
    end

    // Ret+Link on an empty stack degenerates to a plain push.
    assign push   = Link & (~Ret | empty);
    assign ovw    = Link & Ret & ~empty;
    assign pop    = Ret & ~Link & ~empty;
    assign wr_idx = ovw ? top : top + PW'(1);

    always_ff @(posedge CLK or posedge Reset) begin
        if (Reset) begin
            PC  <= RESET_PC;
            top <= '0;
            cnt <= '0;
        end else if (!Stall) begin
            PC <= NextPC;
            if (push) begin
                top <= top + PW'(1);
                if (cnt != FULL)
                    cnt <= cnt + CW'(1);
            end else if (pop) begin
                top <= top - PW'(1);
                cnt <= cnt - CW'(1);
            end
        end
    end

    // Entries are not reset; they are don't-care while the count is zero.
    always_ff @(posedge CLK) begin
        if (!Reset && !Stall && (push || ovw))
            ras[wr_idx] <= seq;
    end

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed self-checking bench for pc_sequencer (WIDTH=64, depth 4,
// RESET_PC=0) using immediate assertions at each check point.
`timescale 1ns/100ps
module tb_pc_sequencer;

    logic        CLK;
    logic        Reset;
    logic        Stall;
    logic        Branch;
    logic        ALUZero;
    logic        Uncondbranch;
    logic        CondBranch;
    logic [3:0]  CondCode;
    logic [3:0]  Flags;
    logic        BranchReg;
    logic        Ret;
    logic        Link;
    logic [63:0] RegTarget;
    logic [63:0] SignExtImm;
    logic [63:0] PC;
    logic [63:0] NextPC;
    logic        Taken;
    logic [2:0]  RasCount;
    logic        RasEmpty;

    int checks = 0;
    int errors = 0;

    pc_sequencer #(.WIDTH(64), .RAS_DEPTH(4), .RESET_PC(64'h0)) dut (
        .CLK(CLK), .Reset(Reset), .Stall(Stall), .Branch(Branch),
        .ALUZero(ALUZero), .Uncondbranch(Uncondbranch),
        .CondBranch(CondBranch), .CondCode(CondCode), .Flags(Flags),
        .BranchReg(BranchReg), .Ret(Ret), .Link(Link),
        .RegTarget(RegTarget), .SignExtImm(SignExtImm), .PC(PC),
        .NextPC(NextPC), .Taken(Taken), .RasCount(RasCount),
        .RasEmpty(RasEmpty)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic clear_in();
        Branch = 0; ALUZero = 0; Uncondbranch = 0; CondBranch = 0;
        CondCode = 0; Flags = 0; BranchReg = 0; Ret = 0; Link = 0;
        RegTarget = 0; SignExtImm = 0;
    endtask

    logic [3:0]  fv [4];
    logic [15:0] mask [4];
    logic [15:0] m;

    initial begin
        fv[0] = 4'b0000; mask[0] = 16'hD6AA;
        fv[1] = 4'b0100; mask[1] = 16'hE6A9;
        fv[2] = 4'b1001; mask[2] = 16'hD65A;
        fv[3] = 4'b0010; mask[3] = 16'hD5A6;

        Reset = 1; Stall = 0;
        clear_in();
        #2;
        chk("rst_pc", PC, 64'h0);
        chk("rst_empty", {63'b0, RasEmpty}, 64'd1);
        chk("rst_cnt", {61'b0, RasCount}, 64'd0);
        chk("rst_next", NextPC, 64'h4);
        @(negedge CLK);
        Reset = 0;
        for (int i = 1; i <= 3; i++) begin
            tick();
            chk("idle_pc", PC, 64'(4 * i));
            chk("idle_taken", {63'b0, Taken}, 64'd0);
            chk("idle_empty", {63'b0, RasEmpty}, 64'd1);
        end

        BranchReg = 1; RegTarget = 64'h103;
        tick();
        chk("br_pc", PC, 64'h100);
        clear_in();
        Stall = 1;
        Branch = 1; ALUZero = 1; SignExtImm = -64'sd2;
        #1;
        chk("cbz_next", NextPC, 64'hF8);
        chk("cbz_taken", {63'b0, Taken}, 64'd1);
        ALUZero = 0;
        #1;
        chk("cbz_nt_next", NextPC, 64'h104);
        chk("cbz_nt_taken", {63'b0, Taken}, 64'd0);
        Branch = 0;
        CondBranch = 1;
        for (int f = 0; f < 4; f++) begin
            Flags = fv[f];
            m = mask[f];
            for (int cc = 0; cc < 16; cc++) begin
                CondCode = 4'(cc);
                #1;
                chk($sformatf("cond_f%0h_c%0d", fv[f], cc),
                    {63'b0, Taken}, {63'b0, m[cc]});
                if (cc == 0)
                    chk("cond_next", NextPC, m[0] ? 64'hF8 : 64'h104);
            end
        end
        chk("stall_sweep_pc", PC, 64'h100);
        clear_in();
        Stall = 0;

        BranchReg = 1; RegTarget = 64'h200;
        tick();
        chk("to200", PC, 64'h200);
        clear_in();
        Uncondbranch = 1; Link = 1; SignExtImm = 64'h40;
        tick();
        chk("bl_pc", PC, 64'h300);
        chk("bl_cnt", {61'b0, RasCount}, 64'd1);
        clear_in();
        Ret = 1;
        #1;
        chk("ret_next", NextPC, 64'h204);
        chk("ret_taken", {63'b0, Taken}, 64'd1);
        tick();
        chk("ret_pc", PC, 64'h204);
        chk("ret_cnt", {61'b0, RasCount}, 64'd0);
        clear_in();

        for (int i = 0; i < 5; i++) begin
            BranchReg = 1; Link = 1;
            RegTarget = 64'h400 + 64'(i) * 64'h100;
            tick();
            chk("push_pc", PC, 64'h400 + 64'(i) * 64'h100);
            chk("push_cnt", {61'b0, RasCount}, (i < 4) ? 64'(i + 1) : 64'd4);
        end
        clear_in();
        Ret = 1; RegTarget = 64'h1003;
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("pop_pc", PC, 64'h704 - 64'(i) * 64'h100);
            chk("pop_cnt", {61'b0, RasCount}, 64'(3 - i));
        end
        tick();
        chk("pop_empty_pc", PC, 64'h1000);
        chk("pop_empty_cnt", {61'b0, RasCount}, 64'd0);
        chk("pop_empty_flag", {63'b0, RasEmpty}, 64'd1);
        clear_in();

        Stall = 1; Uncondbranch = 1; Link = 1; SignExtImm = 64'h4;
        #1;
        chk("stall_next", NextPC, 64'h1010);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("stall_pc", PC, 64'h1000);
            chk("stall_cnt", {61'b0, RasCount}, 64'd0);
        end
        Stall = 0;
        tick();
        chk("unstall_pc", PC, 64'h1010);
        chk("unstall_cnt", {61'b0, RasCount}, 64'd1);
        clear_in();
        #2;
        Reset = 1;
        #1;
        chk("arst_pc", PC, 64'h0);
        chk("arst_cnt", {61'b0, RasCount}, 64'd0);
        chk("arst_empty", {63'b0, RasEmpty}, 64'd1);
        chk("arst_next", NextPC, 64'h4);
        Reset = 0;
        tick();
        chk("post_rst_pc", PC, 64'h4);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
